mesi_isc_broad_dispatch: RTL and testbench
==========================================

// Module: mesi_isc_broad_dispatch
// PURPOSE
//  Reader side of the broadcast FIFO. Pops one broadcast request (breq) at a time.
//  Drives snoop commands on the cbus to every CPU except the originator, then collects their acks.
//  Then grants the originator its access (enable-wr/rd) and waits for its ack.
//  Sits between the broad FIFO and the four CPU cbus ports of the MESI ISC.
// PARAMETERS
//  CBUS_CMD_WIDTH    3    width of each per-CPU cbus command
//  ADDR_WIDTH        32   broadcast address width
//  BROAD_TYPE_WIDTH  2    breq type width (NOP/WR/RD)
//  BROAD_ID_WIDTH    7    breq ID width
//  WDOG_CYCLES       255  watchdog limit in cycles; used only with MESI_ISC_BROAD_WDOG_EN
// PORTS
//  clk                       in   1                    system clock
//  rst                       in   1                    async active-high reset
//  broad_fifo_status_empty_i in   1                    broad FIFO empty
//  broad_addr_i              in   ADDR_WIDTH           FIFO head address (first-word fall-through)
//  broad_type_i              in   BROAD_TYPE_WIDTH     FIFO head type
//  broad_cpu_id_i            in   2                    FIFO head originator CPU
//  broad_id_i                in   BROAD_ID_WIDTH       FIFO head breq ID
//  cbus_ack_array_i          in   4                    per-CPU cbus ack, one-cycle pulse
//  broad_fifo_rd_o           out  1                    pop FIFO head
//  cbus_addr_o               out  ADDR_WIDTH           address of the active breq (shared by all CPUs)
//  cbus_cmd_array_o          out  4*CBUS_CMD_WIDTH     per-CPU cbus command; CPU i at [i*W +: W]
//  broad_id_o                out  BROAD_ID_WIDTH       ID of the active breq
//  busy_o                    out  1                    state != IDLE
//  wdog_err_o                out  1                    sticky watchdog error (0 when the macro is off)
// BEHAVIOUR
//  Reset: state=IDLE, pending=0, every output 0 (cbus cmds = NOP, wdog_err_o=0).
//  Reset mid-transaction abandons the breq; no ack or enable is replayed.
//  FSM states: IDLE, SNOOP, ENABLE.
//  IDLE:
//   - broad_fifo_rd_o = IDLE & ~empty (combinational).
//   - On a pop, latch addr/type/cpu_id/id.
//   - type NOP: discard, stay IDLE.
//   - type WR/RD: pending <= ~onehot(cpu_id), go to SNOOP.
//  SNOOP:
//   - cmd[i] = WR_SNOOP/RD_SNOOP for each pending[i]; NOP elsewhere.
//   - ack[i] & pending[i] clears pending[i] next cycle. Acks on non-pending CPUs are ignored.
//   - When the post-update pending == 0, go to ENABLE. Simultaneous acks are allowed.
//  ENABLE:
//   - cmd[origin] = EN_WR/EN_RD; all other cmds NOP.
//   - ack[origin] returns the FSM to IDLE; other acks are ignored.
//  Outputs are pure functions of registers; cbus cmds never depend combinationally on acks.
//  Latency (pop at cycle t):
//   - snoop cmds visible at t+1.
//   - Last snoop ack at u: enable visible at u+1.
//   - Origin ack at v: IDLE at v+1; next pop possible at v+1; next snoops at v+2.
//  An ack in the first cycle a cmd is visible is legal.
//  cbus_addr_o and broad_id_o hold the latched values until the next pop.
//  Empty FIFO in IDLE: no pop, cmds stay NOP.
// CONFIGURATION
//  MESI_ISC_BROAD_WDOG_EN defined:
//   - 8-bit counter cleared on every state change and on every accepted ack.
//   - Reaching WDOG_CYCLES in SNOOP or ENABLE: wdog_err_o <= 1 (sticky until rst), force IDLE, pending=0.
//  Not defined: no counter; wdog_err_o tied 0; the FSM waits indefinitely.
// STRUCTURE
//  mesi_isc_pkg:
//   - cbus cmd enum: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4.
//   - breq type constants: NOP=0, WR=1, RD=2.
//   - FSM state enum.
//  One sub-module, mesi_isc_broad_cmd_gen: combinational mapping of state/type/pending/origin to the 4 cbus cmds.
// TESTING
//  1. WR breq from cpu1, addr 0x40, no acks:
//     -> rd pulse 1 cycle; cmds CPU0/2/3=WR_SNOOP(1), CPU1=NOP.
//     Ack CPU0, CPU2, CPU3 in separate cycles
//     -> CPU1=EN_WR(3) the cycle after the last ack. Ack CPU1 -> all NOP, busy_o=0.
//  2. RD breq from cpu3; acks 0,1,2 in the same cycle -> next cycle CPU3=EN_RD(4).
//  3. Back-to-back: 2 breqs queued -> second pop the cycle after the origin ack; snoops one cycle later.
//  4. Stray acks (the origin during SNOOP; non-origin CPUs during ENABLE) -> ignored, state unchanged.
//  5. NOP-type head -> popped, no cbus activity, stays IDLE. Assert rst in ENABLE -> cmds NOP immediately.
//  6. MESI_ISC_BROAD_WDOG_EN defined, withhold acks 255 cycles -> wdog_err_o=1, IDLE. Undefined -> waits.

Source files
------------

// File: rtl/mesi_isc_pkg.sv
// ----------------------------------------------------------------------------
// mesi_isc_pkg
// Shared types and constants for the MESI ISC broadcast dispatcher:
//   - cbus_cmd_e : per-CPU cbus command encoding
//   - BREQ_*     : broadcast request type encoding
//   - state_e    : broadcast dispatcher FSM states
// ----------------------------------------------------------------------------
package mesi_isc_pkg;

    localparam int NUM_CPUS = 4;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_WR_SNOOP = 3'd1,
        CMD_RD_SNOOP = 3'd2,
        CMD_EN_WR    = 3'd3,
        CMD_EN_RD    = 3'd4
    } cbus_cmd_e;

    localparam logic [1:0] BREQ_NOP = 2'd0;
    localparam logic [1:0] BREQ_WR  = 2'd1;
    localparam logic [1:0] BREQ_RD  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SNOOP  = 2'd1,
        ST_ENABLE = 2'd2
    } state_e;

    // One-hot mask selecting a single CPU.
    function automatic logic [NUM_CPUS-1:0] cpu_onehot(input logic [1:0] cpu);
        return 4'b0001 << cpu;
    endfunction

endpackage

// File: rtl/mesi_isc_broad_dispatch_if.sv
// ----------------------------------------------------------------------------
// mesi_isc_broad_dispatch_if
// Bundles the broad-FIFO read port and the four-CPU cbus port of the
// broadcast dispatcher. Signal suffixes are from the dispatcher's viewpoint.
//   master : the dispatcher (pops the FIFO, drives cbus commands)
//   slave  : the environment (FIFO head + CPU cbus acks)
// Signals:
//   broad_fifo_status_empty_i  FIFO empty
//   broad_addr_i/type_i/cpu_id_i/id_i  FIFO head (first-word fall-through)
//   cbus_ack_array_i           per-CPU ack pulses
//   broad_fifo_rd_o            FIFO pop
//   cbus_addr_o                active breq address
//   cbus_cmd_array_o           per-CPU cmds, CPU i at [i*W +: W]
//   broad_id_o                 active breq ID
// ----------------------------------------------------------------------------
interface mesi_isc_broad_dispatch_if #(
    parameter int CBUS_CMD_WIDTH   = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 7
);
    logic                          broad_fifo_status_empty_i;
    logic [ADDR_WIDTH-1:0]         broad_addr_i;
    logic [BROAD_TYPE_WIDTH-1:0]   broad_type_i;
    logic [1:0]                    broad_cpu_id_i;
    logic [BROAD_ID_WIDTH-1:0]     broad_id_i;
    logic [3:0]                    cbus_ack_array_i;
    logic                          broad_fifo_rd_o;
    logic [ADDR_WIDTH-1:0]         cbus_addr_o;
    logic [4*CBUS_CMD_WIDTH-1:0]   cbus_cmd_array_o;
    logic [BROAD_ID_WIDTH-1:0]     broad_id_o;

    modport master (
        input  broad_fifo_status_empty_i, broad_addr_i, broad_type_i,
               broad_cpu_id_i, broad_id_i, cbus_ack_array_i,
        output broad_fifo_rd_o, cbus_addr_o, cbus_cmd_array_o, broad_id_o
    );

    modport slave (
        output broad_fifo_status_empty_i, broad_addr_i, broad_type_i,
               broad_cpu_id_i, broad_id_i, cbus_ack_array_i,
        input  broad_fifo_rd_o, cbus_addr_o, cbus_cmd_array_o, broad_id_o
    );
endinterface

// File: rtl/mesi_isc_broad_cmd_gen.sv
// ----------------------------------------------------------------------------
// mesi_isc_broad_cmd_gen
// Combinational mapping of dispatcher state to the four cbus commands.
//   state_i     : dispatcher FSM state
//   type_i      : latched breq type (WR/RD)
//   pending_i   : CPUs still owing a snoop ack
//   origin_i    : originating CPU
//   cmd_array_o : per-CPU command, CPU i at [i*W +: W]
// ----------------------------------------------------------------------------
module mesi_isc_broad_cmd_gen
    import mesi_isc_pkg::*;
#(
    parameter int CBUS_CMD_WIDTH   = 3,
    parameter int BROAD_TYPE_WIDTH = 2
) (
    input  state_e                               state_i,
    input  logic [BROAD_TYPE_WIDTH-1:0]          type_i,
    input  logic [NUM_CPUS-1:0]                  pending_i,
    input  logic [1:0]                           origin_i,
    output logic [NUM_CPUS*CBUS_CMD_WIDTH-1:0]   cmd_array_o
);
    logic      is_rd;
    cbus_cmd_e snoop_cmd;
    cbus_cmd_e enable_cmd;

    assign is_rd      = (type_i == BROAD_TYPE_WIDTH'(BREQ_RD));
    assign snoop_cmd  = is_rd ? CMD_RD_SNOOP : CMD_WR_SNOOP;
    assign enable_cmd = is_rd ? CMD_EN_RD    : CMD_EN_WR;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        cmd_array_o = '0;
        for (int i = 0; i < NUM_CPUS; i++) begin
            if (state_i == ST_SNOOP && pending_i[i]) begin
                cmd_array_o[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = CBUS_CMD_WIDTH'(snoop_cmd);
            end else if (state_i == ST_ENABLE && origin_i == 2'(i)) begin
                cmd_array_o[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = CBUS_CMD_WIDTH'(enable_cmd);
            end
        end
    end
endmodule

// File: rtl/mesi_isc_broad_dispatch.sv
// ----------------------------------------------------------------------------
// mesi_isc_broad_dispatch
// Reader side of the broadcast FIFO. Pops one breq at a time, snoops every
// CPU except the originator, collects their acks, then grants the originator
// its access and waits for its ack.
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : FIFO read port + four-CPU cbus (master modport)
//   busy_o      : FSM not idle
//   wdog_err_o  : sticky watchdog error
// Optional feature: define MESI_ISC_BROAD_WDOG_EN to enable an 8-bit watchdog
// that aborts a breq stalled WDOG_CYCLES cycles in SNOOP or ENABLE.
// ----------------------------------------------------------------------------
module mesi_isc_broad_dispatch
    import mesi_isc_pkg::*;
#(
    parameter int CBUS_CMD_WIDTH   = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 7,
    parameter int WDOG_CYCLES      = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    mesi_isc_broad_dispatch_if.master bus,
    output logic                     busy_o,
    output logic                     wdog_err_o
);
    // The watchdog counter is 8 bits wide.
    if (WDOG_CYCLES < 1 || WDOG_CYCLES > 255) begin : g_wdog_range_check
        $error("WDOG_CYCLES must be in 1..255");
    end

    state_e                        state_q,   state_d;
    logic [NUM_CPUS-1:0]           pending_q, pending_d;
    logic [ADDR_WIDTH-1:0]         addr_q,    addr_d;
    logic [BROAD_TYPE_WIDTH-1:0]   type_q,    type_d;
    logic [1:0]                    origin_q,  origin_d;
    logic [BROAD_ID_WIDTH-1:0]     id_q,      id_d;
    logic                          pop;
    logic                          is_access;

`ifdef MESI_ISC_BROAD_WDOG_EN
    logic [7:0] wdog_cnt_q, wdog_cnt_d;
    logic       wdog_err_q, wdog_err_d;
    logic       wdog_fire;
    logic       ack_taken;
`endif

    assign pop       = (state_q == ST_IDLE) && !bus.broad_fifo_status_empty_i;
    assign is_access = (bus.broad_type_i == BROAD_TYPE_WIDTH'(BREQ_WR)) ||
                       (bus.broad_type_i == BROAD_TYPE_WIDTH'(BREQ_RD));

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        addr_d    = addr_q;
        type_d    = type_q;
        origin_d  = origin_q;
        id_d      = id_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    addr_d   = bus.broad_addr_i;
                    type_d   = bus.broad_type_i;
                    origin_d = bus.broad_cpu_id_i;
                    id_d     = bus.broad_id_i;
                    // NOP (or unknown) heads are discarded without cbus activity.
                    if (is_access) begin
                        pending_d = ~cpu_onehot(bus.broad_cpu_id_i);
                        state_d   = ST_SNOOP;
                    end
                end
            end
            ST_SNOOP: begin
                // Acks from CPUs not pending (including the origin) drop out here.
                pending_d = pending_q & ~bus.cbus_ack_array_i;
                if (pending_d == '0) state_d = ST_ENABLE;
            end
            ST_ENABLE: begin
                if (bus.cbus_ack_array_i[origin_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef MESI_ISC_BROAD_WDOG_EN
        ack_taken = ((state_q == ST_SNOOP) && |(bus.cbus_ack_array_i & pending_q)) ||
                    ((state_q == ST_ENABLE) && bus.cbus_ack_array_i[origin_q]);
        wdog_fire  = (state_q != ST_IDLE) && (wdog_cnt_q == 8'(WDOG_CYCLES));
        wdog_err_d = wdog_err_q | wdog_fire;
        if (wdog_fire) begin
            state_d   = ST_IDLE;
            pending_d = '0;
        end
        wdog_cnt_d = (state_d != state_q || ack_taken || state_q == ST_IDLE) ?
                     8'd0 : wdog_cnt_q + 8'd1;
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            addr_q    <= '0;
            type_q    <= '0;
            origin_q  <= '0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            type_q    <= type_d;
            origin_q  <= origin_d;
            id_q      <= id_d;
        end
    end

`ifdef MESI_ISC_BROAD_WDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end
    assign wdog_err_o = wdog_err_q;
`else
    assign wdog_err_o = 1'b0;
`endif

    mesi_isc_broad_cmd_gen #(
        .CBUS_CMD_WIDTH   (CBUS_CMD_WIDTH),
        .BROAD_TYPE_WIDTH (BROAD_TYPE_WIDTH)
    ) u_cmd_gen (
        .state_i     (state_q),
        .type_i      (type_q),
        .pending_i   (pending_q),
        .origin_i    (origin_q),
        .cmd_array_o (bus.cbus_cmd_array_o)
    );

    assign bus.broad_fifo_rd_o = pop;
    assign bus.cbus_addr_o     = addr_q;
    assign bus.broad_id_o      = id_q;
    assign busy_o              = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mesi_isc_broad_dispatch.sv
// ----------------------------------------------------------------------------
// tb_mesi_isc_broad_dispatch
// Directed bench for mesi_isc_broad_dispatch. A queue models the broad FIFO
// (first-word fall-through); acks are one-cycle pulses driven by the tests.
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns after it.
// ----------------------------------------------------------------------------
module tb_mesi_isc_broad_dispatch;
    import mesi_isc_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  typ;
        logic [1:0]  cpu;
        logic [6:0]  id;
    } breq_t;

    logic  clk;
    logic  rst;
    logic  busy;
    logic  wdog_err;
    int    checks  = 0;
    int    errors  = 0;
    int    pop_cnt = 0;
    breq_t fifo_q[$];

    mesi_isc_broad_dispatch_if bus ();

    mesi_isc_broad_dispatch dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy_o     (busy),
        .wdog_err_o (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    task automatic drive_head();
        if (fifo_q.size() == 0) begin
            bus.broad_fifo_status_empty_i = 1'b1;
        end else begin
            bus.broad_fifo_status_empty_i = 1'b0;
            bus.broad_addr_i   = fifo_q[0].addr;
            bus.broad_type_i   = fifo_q[0].typ;
            bus.broad_cpu_id_i = fifo_q[0].cpu;
            bus.broad_id_i     = fifo_q[0].id;
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [1:0] t,
                        input logic [1:0] c, input logic [6:0] id);
        breq_t b;
        b.addr = a; b.typ = t; b.cpu = c; b.id = id;
        fifo_q.push_back(b);
        drive_head();
        #1;
    endtask

    // One clock: sample the pop request at the falling edge, advance the FIFO
    // model after the rising edge, and retire any ack pulse.
    task automatic step();
        logic pop;
        @(negedge clk);
        pop = bus.broad_fifo_rd_o;
        @(posedge clk);
        #1;
        bus.cbus_ack_array_i = 4'b0000;
        if (pop && fifo_q.size() > 0) begin
            fifo_q.delete(0);
            pop_cnt++;
        end
        drive_head();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cbus_ack_array_i = 4'b0000;
        bus.broad_addr_i = '0; bus.broad_type_i = '0;
        bus.broad_cpu_id_i = '0; bus.broad_id_i = '0;
        drive_head();
        #12;
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: cmds=%h busy=%b, required cmds=000 busy=0", bus.cbus_cmd_array_o, busy);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (bus.broad_fifo_rd_o !== 1'b0 || bus.cbus_addr_o !== 32'h0 || bus.broad_id_o !== 7'h0 || wdog_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%b addr=%h id=%h wdog=%b, required all 0",
                     bus.broad_fifo_rd_o, bus.cbus_addr_o, bus.broad_id_o, wdog_err);
        end
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_empty: cmds=%h busy=%b, required cmds=000 busy=0", bus.cbus_cmd_array_o, busy);
        end
    endtask

    task automatic test_wr_snoop();
        int pops0;
        pops0 = pop_cnt;
        push(32'h40, BREQ_WR, 2'd1, 7'h11);
        checks++;
        if (bus.broad_fifo_rd_o !== 1'b1) begin
            errors++;
            $display("FAIL wr_rd_req: rd=%b, required 1", bus.broad_fifo_rd_o);
        end
        step();
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h241 || busy !== 1'b1 || bus.broad_fifo_rd_o !== 1'b0) begin
            errors++;
            $display("FAIL wr_snoop_cmds: cmds=%h busy=%b rd=%b, required 241 1 0",
                     bus.cbus_cmd_array_o, busy, bus.broad_fifo_rd_o);
        end
        checks++;
        if (bus.cbus_addr_o !== 32'h40 || bus.broad_id_o !== 7'h11 || pop_cnt - pops0 !== 1) begin
            errors++;
            $display("FAIL wr_latch: addr=%h id=%h pops=%0d, required 40 11 1",
                     bus.cbus_addr_o, bus.broad_id_o, pop_cnt - pops0);
        end
        bus.cbus_ack_array_i = 4'b0001;
        step();
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h240) begin
            errors++;
            $display("FAIL wr_ack_cpu0: cmds=%h, required 240", bus.cbus_cmd_array_o);
        end
        bus.cbus_ack_array_i = 4'b0100;
        step();
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h200) begin
            errors++;
            $display("FAIL wr_ack_cpu2: cmds=%h, required 200", bus.cbus_cmd_array_o);
        end
        bus.cbus_ack_array_i = 4'b1000;
        step();
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h018 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_enable: cmds=%h busy=%b, required 018 1", bus.cbus_cmd_array_o, busy);
        end
        bus.cbus_ack_array_i = 4'b0010;
        step();
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h000 || busy !== 1'b0 || pop_cnt - pops0 !== 1) begin
            errors++;
            $display("FAIL wr_done: cmds=%h busy=%b pops=%0d, required 000 0 1",
                     bus.cbus_cmd_array_o, busy, pop_cnt - pops0);
        end
    endtask

    task automatic test_rd_simul_acks();
        push(32'h1234_5678, BREQ_RD, 2'd3, 7'h22);
        step();
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h092 || bus.cbus_addr_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd_snoop_cmds: cmds=%h addr=%h, required 092 12345678",
                     bus.cbus_cmd_array_o, bus.cbus_addr_o);
        end
        bus.cbus_ack_array_i = 4'b0111;
        step();
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h800) begin
            errors++;
            $display("FAIL rd_enable: cmds=%h, required 800", bus.cbus_cmd_array_o);
        end
        bus.cbus_ack_array_i = 4'b1000;
        step();
        checks++;
        if (busy !== 1'b0 || bus.cbus_cmd_array_o !== 12'h000) begin
            errors++;
            $display("FAIL rd_done: busy=%b cmds=%h, required 0 000", busy, bus.cbus_cmd_array_o);
        end
    endtask

    task automatic test_back_to_back();
        push(32'h100, BREQ_WR, 2'd0, 7'h01);
        push(32'h200, BREQ_RD, 2'd2, 7'h02);
        step();
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h248 || bus.broad_fifo_rd_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_snoop: cmds=%h rd=%b, required 248 0",
                     bus.cbus_cmd_array_o, bus.broad_fifo_rd_o);
        end
        bus.cbus_ack_array_i = 4'b1110;
        step();
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h003) begin
            errors++;
            $display("FAIL b2b_first_enable: cmds=%h, required 003", bus.cbus_cmd_array_o);
        end
        bus.cbus_ack_array_i = 4'b0001;
        step();
        checks++;
        if (busy !== 1'b0 || bus.broad_fifo_rd_o !== 1'b1 || bus.cbus_cmd_array_o !== 12'h000 ||
            bus.cbus_addr_o !== 32'h100) begin
            errors++;
            $display("FAIL b2b_second_pop: busy=%b rd=%b cmds=%h addr=%h, required 0 1 000 100",
                     busy, bus.broad_fifo_rd_o, bus.cbus_cmd_array_o, bus.cbus_addr_o);
        end
        step();
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h412 || bus.cbus_addr_o !== 32'h200 || bus.broad_id_o !== 7'h02) begin
            errors++;
            $display("FAIL b2b_second_snoop: cmds=%h addr=%h id=%h, required 412 200 02",
                     bus.cbus_cmd_array_o, bus.cbus_addr_o, bus.broad_id_o);
        end
        bus.cbus_ack_array_i = 4'b1011;
        step();
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h100) begin
            errors++;
            $display("FAIL b2b_second_enable: cmds=%h, required 100", bus.cbus_cmd_array_o);
        end
        bus.cbus_ack_array_i = 4'b0100;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_stray_acks();
        push(32'h300, BREQ_WR, 2'd2, 7'h03);
        step();
        bus.cbus_ack_array_i = 4'b0100;
        step();
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h209 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stray_origin_in_snoop: cmds=%h busy=%b, required 209 1", bus.cbus_cmd_array_o, busy);
        end
        bus.cbus_ack_array_i = 4'b1011;
        step();
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h0C0) begin
            errors++;
            $display("FAIL stray_enable: cmds=%h, required 0c0", bus.cbus_cmd_array_o);
        end
        bus.cbus_ack_array_i = 4'b1011;
        step();
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h0C0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stray_others_in_enable: cmds=%h busy=%b, required 0c0 1", bus.cbus_cmd_array_o, busy);
        end
        bus.cbus_ack_array_i = 4'b0100;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_done: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_nop_and_reset();
        int pops0;
        pops0 = pop_cnt;
        push(32'h500, BREQ_NOP, 2'd1, 7'h05);
        checks++;
        if (bus.broad_fifo_rd_o !== 1'b1) begin
            errors++;
            $display("FAIL nop_rd_req: rd=%b, required 1", bus.broad_fifo_rd_o);
        end
        step();
        checks++;
        if (busy !== 1'b0 || bus.cbus_cmd_array_o !== 12'h000 || pop_cnt - pops0 !== 1 ||
            bus.broad_id_o !== 7'h05 || bus.cbus_addr_o !== 32'h500) begin
            errors++;
            $display("FAIL nop_discard: busy=%b cmds=%h pops=%0d id=%h addr=%h, required 0 000 1 05 500",
                     busy, bus.cbus_cmd_array_o, pop_cnt - pops0, bus.broad_id_o, bus.cbus_addr_o);
        end
        push(32'h600, BREQ_WR, 2'd0, 7'h06);
        step();
        bus.cbus_ack_array_i = 4'b1110;
        step();
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h003) begin
            errors++;
            $display("FAIL rst_pre_enable: cmds=%h, required 003", bus.cbus_cmd_array_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h000 || busy !== 1'b0 || bus.broad_id_o !== 7'h00) begin
            errors++;
            $display("FAIL rst_async: cmds=%h busy=%b id=%h, required 000 0 00",
                     bus.cbus_cmd_array_o, busy, bus.broad_id_o);
        end
        step();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (bus.cbus_cmd_array_o !== 12'h000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_replay: cmds=%h busy=%b, required 000 0", bus.cbus_cmd_array_o, busy);
        end
    endtask

    task automatic test_wdog();
        push(32'h700, BREQ_WR, 2'd1, 7'h07);
        step();
`ifdef MESI_ISC_BROAD_WDOG_EN
        begin
            int n;
            n = 0;
            while (busy === 1'b1 && n < 300) begin
                step();
                n++;
            end
            checks++;
            if (n !== 256 || wdog_err !== 1'b1 || bus.cbus_cmd_array_o !== 12'h000) begin
                errors++;
                $display("FAIL wdog_fire: cycles=%0d wdog=%b cmds=%h, required 256 1 000",
                         n, wdog_err, bus.cbus_cmd_array_o);
            end
        end
`else
        for (int i = 0; i < 300; i++) step();
        checks++;
        if (busy !== 1'b1 || bus.cbus_cmd_array_o !== 12'h241 || wdog_err !== 1'b0) begin
            errors++;
            $display("FAIL wdog_off_wait: busy=%b cmds=%h wdog=%b, required 1 241 0",
                     busy, bus.cbus_cmd_array_o, wdog_err);
        end
        bus.cbus_ack_array_i = 4'b1101;
        step();
        bus.cbus_ack_array_i = 4'b0010;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wdog_off_done: busy=%b, required 0", busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_wr_snoop();
        test_rd_simul_acks();
        test_back_to_back();
        test_stray_acks();
        test_nop_and_reset();
        test_wdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
